burst_line_adapter: RTL and testbench

- Converts the L2 cache's single 256-bit line transfers into 64-bit four-beat bursts on the physical memory bus, and back again.
- Sits directly downstream of l2_cache. Its cache side connects to the pmem_* ports of l2_cache; its memory side connects to physical memory.
- Serves exactly one outstanding line read or line write at a time.

---
 rtl/burst_line_adapter.sv | 109 ++++++++++
 tb/tb_burst_line_adapter.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_line_adapter.sv
// Line-to-burst adapter between l2_cache and physical memory.
// Splits one cache line into n_beats memory beats and reassembles reads.
module burst_line_adapter #(
    parameter int s_burst  = 64,
    parameter int n_beats  = 4,
    parameter int s_line   = s_burst * n_beats,
    parameter int s_offset = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [s_line-1:0] line_i,
    output logic [s_line-1:0] line_o,
    input  logic [31:0]       address_i,
    input  logic              read_i,
    input  logic              write_i,
    output logic              resp_o,
    input  logic [s_burst-1:0] burst_i,
    output logic [s_burst-1:0] burst_o,
    output logic [31:0]       address_o,
    output logic              read_o,
    output logic              write_o,
    input  logic              resp_i
);

    localparam int CW = (n_beats > 1) ? $clog2(n_beats) : 1;
    localparam logic [CW-1:0] LAST = CW'(n_beats - 1);
    localparam logic [31:0] ALIGN = ~((32'd1 << s_offset) - 32'd1);

    typedef enum logic [1:0] {
        IDLE,
        RD_BURST,
        WR_BURST,
        DONE
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [s_line-1:0] wbuf_q, wbuf_d;
    logic [s_line-1:0] line_q, line_d;
    logic [31:0]       addr_q, addr_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wbuf_q  <= '0;
            line_q  <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wbuf_q  <= wbuf_d;
            line_q  <= line_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wbuf_d  = wbuf_q;
        line_d  = line_q;
        addr_d  = addr_q;
        read_o  = 1'b0;
        write_o = 1'b0;
        resp_o  = 1'b0;
        burst_o = '0;
        unique case (state_q)
            IDLE: begin
                // write has priority over a simultaneous read
                if (write_i) begin
                    wbuf_d  = line_i;
                    addr_d  = address_i & ALIGN;
                    cnt_d   = '0;
                    state_d = WR_BURST;
                end else if (read_i) begin
                    addr_d  = address_i & ALIGN;
                    cnt_d   = '0;
                    state_d = RD_BURST;
                end
            end
            RD_BURST: begin
                read_o = 1'b1;
                if (resp_i) begin
                    line_d[int'(cnt_q)*s_burst +: s_burst] = burst_i;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST) state_d = DONE;
                end
            end
            WR_BURST: begin
                write_o = 1'b1;
                burst_o = wbuf_q[int'(cnt_q)*s_burst +: s_burst];
                if (resp_i) begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST) state_d = DONE;
                end
            end
            DONE: begin
                resp_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign line_o    = line_q;
    assign address_o = addr_q;

endmodule

// File: tb/tb_burst_line_adapter.sv
// Randomized self-checking bench for burst_line_adapter.
// A memory model drives beats; expectations come from line-level rules.
module tb_burst_line_adapter;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [255:0] line_i = '0;
    logic [255:0] line_o;
    logic [31:0]  address_i = '0;
    logic         read_i = 1'b0;
    logic         write_i = 1'b0;
    logic         resp_o;
    logic [63:0]  burst_i = '0;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i = 1'b0;

    int checks = 0;
    int errors = 0;

    // observations from the last transfer
    logic [255:0] acc;
    logic [255:0] line_done;
    logic [31:0]  addr_seen;
    logic [63:0]  wtrace[$];
    int nacc, rdo_n, wro_n, resp_n, lat, first_act;
    bit tmo, addr_bad;

    burst_line_adapter dut (
        .clk(clk), .rst(rst),
        .line_i(line_i), .line_o(line_o),
        .address_i(address_i), .read_i(read_i),
        .write_i(write_i), .resp_o(resp_o),
        .burst_i(burst_i), .burst_o(burst_o),
        .address_o(address_o), .read_o(read_o),
        .write_o(write_o), .resp_i(resp_i)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] rnd256();
        return {$urandom, $urandom, $urandom, $urandom,
                $urandom, $urandom, $urandom, $urandom};
    endfunction

    // Behaves as l2_cache plus memory for one line transfer.
    task automatic xfer(input bit wr, input bit rd,
                        input logic [31:0] addr,
                        input logic [255:0] wline,
                        input logic [255:0] rbeats,
                        input int k, input int gap_pct,
                        input logic [15:0] pat, input int pat_len,
                        input bit drop);
        int cyc;
        int bidx;
        bit done;
        wtrace.delete();
        acc = '0; nacc = 0; rdo_n = 0; wro_n = 0; resp_n = 0;
        lat = -1; first_act = -1; tmo = 0; addr_bad = 0;
        addr_seen = '0; line_done = '0; bidx = 0;
        read_i = rd; write_i = wr; address_i = addr;
        line_i = wline; resp_i = 1'b0; burst_i = {$urandom, $urandom};
        @(posedge clk); #1;
        cyc = 1; done = 0;
        while (!done && cyc < 200) begin
            address_i = $urandom;
            line_i = rnd256();
            if (resp_o || (drop && cyc >= 2)) begin
                read_i = 1'b0; write_i = 1'b0;
            end
            if (pat_len > 0)
                resp_i = (cyc - 1 < pat_len) ? pat[cyc-1] : 1'b1;
            else if (cyc <= k)
                resp_i = 1'b0;
            else
                resp_i = ($urandom_range(99) >= gap_pct);
            if (resp_i && bidx < 4)
                burst_i = rbeats[bidx*64 +: 64];
            else
                burst_i = {$urandom, $urandom};
            @(negedge clk);
            if ((read_o || write_o) && first_act < 0) begin
                first_act = cyc;
                addr_seen = address_o;
            end else if ((read_o || write_o) && address_o !== addr_seen) begin
                addr_bad = 1;
            end
            if (read_o) begin
                rdo_n++;
                if (resp_i) bidx++;
            end
            if (write_o) begin
                wro_n++;
                wtrace.push_back(burst_o);
                if (resp_i && nacc < 4) begin
                    acc[nacc*64 +: 64] = burst_o;
                    nacc++;
                end
            end
            if (resp_o) begin
                resp_n++;
                lat = cyc;
                line_done = line_o;
                done = 1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        tmo = !done;
        read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({read_o, write_o, resp_o} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctl got %b exp 000", {read_o, write_o, resp_o});
        end
        checks++;
        if (line_o !== '0 || burst_o !== '0 || address_o !== '0) begin
            errors++;
            $display("FAIL reset_data got %h %h %h exp 0", line_o, burst_o, address_o);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_read_nogap();
        logic [255:0] b;
        b = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
        xfer(0, 1, 32'h0000_1234, rnd256(), b, 0, 0, '0, 0, 0);
        checks++;
        if (tmo) begin errors++; $display("FAIL rd_timeout got 1 exp 0"); end
        checks++;
        if (addr_seen !== 32'h0000_1220 || addr_bad) begin
            errors++;
            $display("FAIL rd_addr got %h bad %0d exp 00001220", addr_seen, addr_bad);
        end
        checks++;
        if (rdo_n !== 4 || wro_n !== 0) begin
            errors++;
            $display("FAIL rd_beats got rd %0d wr %0d exp 4 0", rdo_n, wro_n);
        end
        checks++;
        if (lat !== 5 || resp_n !== 1) begin
            errors++;
            $display("FAIL rd_lat got %0d resp %0d exp 5 1", lat, resp_n);
        end
        checks++;
        if (line_done !== b || line_o !== b) begin
            errors++;
            $display("FAIL rd_line got %h exp %h", line_done, b);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (resp_o !== 1'b0 || read_o !== 1'b0) begin
                errors++;
                $display("FAIL rd_extra_resp got %b%b exp 00", resp_o, read_o);
            end
            @(posedge clk); #1;
        end
        b = rnd256();
        xfer(0, 1, $urandom, rnd256(), b, 2, 0, '0, 0, 0);
        checks++;
        if (lat !== 7 || line_o !== b) begin
            errors++;
            $display("FAIL rd_lat_k2 got %0d %h exp 7 %h", lat, line_o, b);
        end
    endtask

    task automatic test_write_gapped();
        logic [255:0] w;
        logic [255:0] prev;
        logic [63:0] e[6];
        w = {64'hD, 64'hC, 64'hB, 64'hA};
        e = '{64'hA, 64'hB, 64'hB, 64'hC, 64'hD, 64'hD};
        prev = line_o;
        xfer(1, 0, 32'h8000_00FF, w, rnd256(), 0, 0, 16'h002D, 6, 0);
        checks++;
        if (tmo || resp_n !== 1) begin
            errors++;
            $display("FAIL wr_resp got %0d tmo %0d exp 1", resp_n, tmo);
        end
        checks++;
        if (wro_n !== 6 || rdo_n !== 0) begin
            errors++;
            $display("FAIL wr_cycles got %0d rd %0d exp 6 0", wro_n, rdo_n);
        end
        if (wtrace.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (wtrace[i] !== e[i]) begin
                    errors++;
                    $display("FAIL wr_trace%0d got %h exp %h", i, wtrace[i], e[i]);
                end
            end
        end else begin
            checks++; errors++;
            $display("FAIL wr_trace_len got %0d exp 6", wtrace.size());
        end
        checks++;
        if (acc !== w || addr_seen !== 32'h8000_00E0) begin
            errors++;
            $display("FAIL wr_data got %h %h exp %h 800000e0", acc, addr_seen, w);
        end
        checks++;
        if (line_o !== prev) begin
            errors++;
            $display("FAIL wr_line_o got %h exp %h", line_o, prev);
        end
    endtask

    task automatic test_simultaneous();
        logic [255:0] w;
        logic [255:0] prev;
        w = rnd256();
        prev = line_o;
        xfer(1, 1, 32'h0000_5A5F, w, rnd256(), 0, 30, '0, 0, 0);
        checks++;
        if (tmo || rdo_n !== 0 || resp_n !== 1) begin
            errors++;
            $display("FAIL both_rd got rd %0d resp %0d exp 0 1", rdo_n, resp_n);
        end
        checks++;
        if (acc !== w || nacc !== 4 || line_o !== prev) begin
            errors++;
            $display("FAIL both_wr got %h exp %h", acc, w);
        end
    endtask

    task automatic test_spurious();
        logic [255:0] prev;
        logic [255:0] b;
        prev = line_o;
        for (int i = 0; i < 3; i++) begin
            resp_i = 1'b1;
            burst_i = {$urandom, $urandom};
            @(negedge clk);
            checks++;
            if ({read_o, write_o, resp_o} !== 3'b000 || line_o !== prev) begin
                errors++;
                $display("FAIL spur got %b exp 000", {read_o, write_o, resp_o});
            end
            @(posedge clk); #1;
        end
        resp_i = 1'b0;
        b = rnd256();
        xfer(0, 1, $urandom, rnd256(), b, 1, 40, '0, 0, 0);
        checks++;
        if (tmo || line_o !== b || rdo_n < 4) begin
            errors++;
            $display("FAIL spur_read got %h exp %h", line_o, b);
        end
    endtask

    task automatic test_back_to_back();
        logic [255:0] b;
        logic [255:0] w;
        int pulses;
        b = rnd256();
        w = rnd256();
        xfer(0, 1, 32'h0000_4000, rnd256(), b, 0, 0, '0, 0, 0);
        pulses = resp_n;
        xfer(1, 0, 32'h0000_4020, w, rnd256(), 0, 0, '0, 0, 0);
        pulses += resp_n;
        checks++;
        if (first_act !== 1) begin
            errors++;
            $display("FAIL b2b_rise got %0d exp 1", first_act);
        end
        checks++;
        if (pulses !== 2 || acc !== w || line_o !== b) begin
            errors++;
            $display("FAIL b2b_data got pulses %0d exp 2", pulses);
        end
    endtask

    task automatic test_reset_midread();
        logic [255:0] e;
        read_i = 1'b1;
        address_i = 32'hABCD_0040;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            resp_i = 1'b1;
            burst_i = {$urandom, $urandom};
            @(posedge clk); #1;
        end
        resp_i = 1'b0;
        read_i = 1'b0;
        checks++;
        if (read_o !== 1'b1) begin
            errors++;
            $display("FAIL mid_active got %b exp 1", read_o);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({read_o, write_o, resp_o} !== 3'b000) begin
            errors++;
            $display("FAIL mid_rst_ctl got %b exp 000", {read_o, write_o, resp_o});
        end
        checks++;
        if (line_o !== '0 || address_o !== '0 || burst_o !== '0) begin
            errors++;
            $display("FAIL mid_rst_data got %h %h exp 0", line_o, address_o);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        e = {{8{8'hE4}}, {8{8'hE3}}, {8{8'hE2}}, {8{8'hE1}}};
        xfer(0, 1, 32'h0000_0100, rnd256(), e, 0, 25, '0, 0, 0);
        checks++;
        if (tmo || line_o !== e || resp_n !== 1) begin
            errors++;
            $display("FAIL mid_reread got %h exp %h", line_o, e);
        end
    endtask

    task automatic test_random();
        logic [255:0] exp_line;
        logic [255:0] w;
        logic [255:0] b;
        logic [31:0] a;
        int op, k, gap;
        bit drop;
        exp_line = line_o;
        for (int n = 0; n < 25; n++) begin
            op = $urandom_range(2);
            k = $urandom_range(3);
            gap = ($urandom_range(3) == 0) ? 0 : $urandom_range(60);
            drop = $urandom_range(1);
            a = $urandom; w = rnd256(); b = rnd256();
            xfer(op != 0, op != 1, a, w, b, k, gap, '0, 0, drop);
            if (op == 0) exp_line = b;
            checks++;
            if (tmo || resp_n !== 1) begin
                errors++;
                $display("FAIL rnd%0d_resp got %0d tmo %0d exp 1", n, resp_n, tmo);
            end
            checks++;
            if (addr_seen !== {a[31:5], 5'b0} || addr_bad) begin
                errors++;
                $display("FAIL rnd%0d_addr got %h exp %h", n, addr_seen, {a[31:5], 5'b0});
            end
            checks++;
            if (line_o !== exp_line) begin
                errors++;
                $display("FAIL rnd%0d_line got %h exp %h", n, line_o, exp_line);
            end
            if (op != 0) begin
                checks++;
                if (acc !== w || nacc !== 4 || rdo_n !== 0) begin
                    errors++;
                    $display("FAIL rnd%0d_wr got %h exp %h", n, acc, w);
                end
            end
            if (gap == 0) begin
                checks++;
                if (lat !== k + 5) begin
                    errors++;
                    $display("FAIL rnd%0d_lat got %0d exp %0d", n, lat, k + 5);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_read_nogap();
        test_write_gapped();
        test_simultaneous();
        test_spurious();
        test_back_to_back();
        test_reset_midread();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
